// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execution sequencer: FSM states, op_code
// field positions and the bit positions inside the architectural flag register.
package alu_exec_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_RN_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    localparam int OP_AF_HI  = 7;
    localparam int OP_AF_LO  = 4;
    localparam int OP_ASEL   = 3;
    localparam int OP_BSEL   = 2;
    localparam int OP_DEST   = 1;
    localparam int OP_FLAGEN = 0;

    localparam int FLAG_P   = 3;
    localparam int FLAG_POS = 2;
    localparam int FLAG_C   = 1;
    localparam int FLAG_Z   = 0;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Op request/completion handshake between an issuing master and the ALU
// execution sequencer.
interface alu_exec_ctrl_if #(
    parameter int RN_W = 3
);
    logic            op_valid;
    logic            op_ready;
    logic [7:0]      op_code;
    logic [RN_W-1:0] op_rn;
    logic [7:0]      op_imm;
    logic            op_done;
    logic            busy;

    modport master (
        output op_valid, op_code, op_rn, op_imm,
        input  op_ready, op_done, busy
    );

    modport slave (
        input  op_valid, op_code, op_rn, op_imm,
        output op_ready, op_done, busy
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Five-state sequencer for the 8-bit ALU: reads R0 and RN, drives the ALU,
// captures result/flags and writes the result back to the register file.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int              DATA_W  = DEFAULT_DATA_W,
    parameter int              RN_W    = DEFAULT_RN_W,
    parameter logic [RN_W-1:0] R0_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_ctrl_if.slave    op,
    output logic [RN_W-1:0]   rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_we,
    output logic [RN_W-1:0]   rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [3:0]        alu_s_af,
    output logic              alu_s3,
    output logic              alu_s4,
    output logic [DATA_W-1:0] alu_r0,
    output logic [DATA_W-1:0] alu_rn,
    output logic [DATA_W-1:0] alu_or2,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags_q
);

    state_t            state_q;
    logic              ready_q;
    logic [7:0]        opCode_q;
    logic [RN_W-1:0]   rn_q;
    logic [RN_W-1:0]   rdAddr_q;
    logic [3:0]        sAf_q;
    logic              s3_q;
    logic              s4_q;
    logic [DATA_W-1:0] r0_q;
    logic [DATA_W-1:0] rnData_q;
    logic [DATA_W-1:0] or2_q;
    logic              we_q;
    logic [RN_W-1:0]   wrAddr_q;
    logic [DATA_W-1:0] wrData_q;
    logic              done_q;

    // Carry-in comes from the flags as they stood before this op's EXEC,
    // so multi-byte ADC/SBC chains see the previous op's carry.
    assign alu_cin    = flags_q[FLAG_C];
    assign op.op_ready = ready_q;
    assign op.busy     = ~ready_q;
    assign op.op_done  = done_q;
    assign rf_rd_addr  = rdAddr_q;
    assign rf_we       = we_q;
    assign rf_wr_addr  = wrAddr_q;
    assign rf_wr_data  = wrData_q;
    assign alu_s_af    = sAf_q;
    assign alu_s3      = s3_q;
    assign alu_s4      = s4_q;
    assign alu_r0      = r0_q;
    assign alu_rn      = rnData_q;
    assign alu_or2     = or2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            opCode_q <= '0;
            rn_q     <= '0;
            rdAddr_q <= '0;
            sAf_q    <= '0;
            s3_q     <= 1'b0;
            s4_q     <= 1'b0;
            r0_q     <= '0;
            rnData_q <= '0;
            or2_q    <= '0;
            flags_q  <= '0;
            we_q     <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            done_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (op.op_valid) begin
                        opCode_q <= op.op_code;
                        rn_q     <= op.op_rn;
                        or2_q    <= op.op_imm;
                        sAf_q    <= op.op_code[OP_AF_HI:OP_AF_LO];
                        s3_q     <= op.op_code[OP_ASEL];
                        s4_q     <= op.op_code[OP_BSEL];
                        rdAddr_q <= R0_ADDR;
                        ready_q  <= 1'b0;
                        state_q  <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    r0_q     <= rf_rd_data;
                    rdAddr_q <= rn_q;
                    state_q  <= ST_RD1;
                end
                ST_RD1: begin
                    rnData_q <= rf_rd_data;
                    rdAddr_q <= R0_ADDR;
                    state_q  <= ST_EXEC;
                end
                // Result and write-back controls are registered here so they
                // appear together as a single-cycle pulse during WB.
                ST_EXEC: begin
                    wrData_q <= alu_out;
                    wrAddr_q <= opCode_q[OP_DEST] ? rn_q : R0_ADDR;
                    we_q     <= 1'b1;
                    done_q   <= 1'b1;
                    if (opCode_q[OP_FLAGEN]) begin
                        flags_q <= alu_flags;
                    end
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a register-file model, a small ALU
// model and a write-back scoreboard.
module tb_alu_exec_ctrl;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic [3:0] flags;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] rfRdAddr;
    logic [7:0] rfRdData;
    logic       rfWe;
    logic [2:0] rfWrAddr;
    logic [7:0] rfWrData;
    logic [3:0] aluSAf;
    logic       aluS3;
    logic       aluS4;
    logic [7:0] aluR0;
    logic [7:0] aluRn;
    logic [7:0] aluOr2;
    logic       aluCin;
    logic [7:0] aluOut;
    logic [3:0] aluFlags;
    logic [3:0] flagsQ;

    logic [7:0] rf [8];
    logic       loadEn;
    logic [2:0] loadAddr;
    logic [7:0] loadData;

    exp_t sbQ[$];
    int   acceptQ[$];
    int   acceptLog[$];
    int   cyc;
    int   checks;
    int   errors;

    alu_exec_ctrl_if #(.RN_W(3)) opIf ();

    alu_exec_ctrl #(.DATA_W(8), .RN_W(3), .R0_ADDR(3'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (opIf),
        .rf_rd_addr (rfRdAddr),
        .rf_rd_data (rfRdData),
        .rf_we      (rfWe),
        .rf_wr_addr (rfWrAddr),
        .rf_wr_data (rfWrData),
        .alu_s_af   (aluSAf),
        .alu_s3     (aluS3),
        .alu_s4     (aluS4),
        .alu_r0     (aluR0),
        .alu_rn     (aluRn),
        .alu_or2    (aluOr2),
        .alu_cin    (aluCin),
        .alu_out    (aluOut),
        .alu_flags  (aluFlags),
        .flags_q    (flagsQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rfRdData = rf[rfRdAddr];

    always @(posedge clk) begin
        if (rfWe) begin
            rf[rfWrAddr] = rfWrData;
        end else if (loadEn) begin
            rf[loadAddr] = loadData;
        end
    end

    // ALU model: ZERO, ADD, ADD with carry, OR; anything else is XOR.
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic [8:0] aluSum;
    always_comb begin
        aluA   = aluS3 ? aluRn : aluR0;
        aluB   = aluS4 ? aluOr2 : aluRn;
        aluSum = '0;
        case (aluSAf)
            4'h0:    aluSum = '0;
            4'h8:    aluSum = {1'b0, aluA} + {1'b0, aluB};
            4'hA:    aluSum = {1'b0, aluA} + {1'b0, aluB} + {8'd0, aluCin};
            4'hD:    aluSum = {1'b0, aluA | aluB};
            default: aluSum = {1'b0, aluA ^ aluB};
        endcase
        aluOut   = aluSum[7:0];
        aluFlags = {^aluSum[7:0], ~aluSum[7], aluSum[8], aluSum[7:0] == 8'h00};
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && opIf.op_valid && opIf.op_ready) begin
            acceptQ.push_back(cyc);
            acceptLog.push_back(cyc);
        end
        cyc++;
    end

    // Scoreboard: every write-back is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rfWe) begin
            if (sbQ.size() == 0) begin
                checkOutput("spurious_we", {15'd0, rfWe}, 16'd0);
            end else begin
                exp_t e;
                int   acc;
                e = sbQ.pop_front();
                acc = (acceptQ.size() != 0) ? acceptQ.pop_front() : -100;
                checkOutput("wb_addr", {13'd0, rfWrAddr}, {13'd0, e.addr});
                checkOutput("wb_data", {8'd0, rfWrData}, {8'd0, e.data});
                checkOutput("wb_flags", {12'd0, flagsQ}, {12'd0, e.flags});
                checkOutput("wb_done", {15'd0, opIf.op_done}, 16'd1);
                checkOutput("wb_latency", 16'(cyc - acc), 16'd4);
            end
        end
    end

    task automatic loadReg(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        loadAddr = addr;
        loadData = data;
        loadEn   = 1'b1;
        @(negedge clk);
        loadEn   = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || !opIf.op_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 16'(n < 20), 16'd1);
    endtask

    // Issues one op, then scrambles the request fields so the DUT must rely
    // on what it latched at accept.
    task automatic applyStimulus(input logic [7:0] code, input logic [2:0] rn, input logic [7:0] imm,
                                 input logic [2:0] expAddr, input logic [7:0] expData,
                                 input logic [3:0] expFlags);
        exp_t e;
        @(negedge clk);
        e.addr  = expAddr;
        e.data  = expData;
        e.flags = expFlags;
        sbQ.push_back(e);
        checkOutput("ready_before_issue", {15'd0, opIf.op_ready}, 16'd1);
        opIf.op_valid = 1'b1;
        opIf.op_code  = code;
        opIf.op_rn    = rn;
        opIf.op_imm   = imm;
        @(negedge clk);
        checkOutput("busy_after_accept", {15'd0, opIf.busy}, 16'd1);
        opIf.op_valid = 1'b0;
        opIf.op_code  = ~code;
        opIf.op_rn    = ~rn;
        opIf.op_imm   = ~imm;
        waitIdle("op_complete_timeout");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startIdx;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        loadEn        = 1'b0;
        loadAddr      = '0;
        loadData      = '0;
        rst_n         = 1'b0;
        opIf.op_valid = 1'b0;
        opIf.op_code  = '0;
        opIf.op_rn    = '0;
        opIf.op_imm   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {15'd0, opIf.op_ready}, 16'd1);
        checkOutput("rst_busy", {15'd0, opIf.busy}, 16'd0);
        checkOutput("rst_flags", {12'd0, flagsQ}, 16'd0);
        checkOutput("rst_we", {15'd0, rfWe}, 16'd0);
        checkOutput("rst_done", {15'd0, opIf.op_done}, 16'd0);
        checkOutput("rst_saf", {12'd0, aluSAf}, 16'd0);
        rst_n = 1'b1;

        $display("[TB] ADD into RN with flags");
        loadReg(3'd0, 8'h05);
        loadReg(3'd3, 8'h0A);
        applyStimulus(8'h83, 3'd3, 8'h00, 3'd3, 8'h0F, 4'b0100);

        $display("[TB] ADD overflow into R0");
        loadReg(3'd0, 8'hFF);
        loadReg(3'd1, 8'h01);
        applyStimulus(8'h81, 3'd1, 8'h00, 3'd0, 8'h00, 4'b0111);

        $display("[TB] ADD with carry-in from previous op");
        loadReg(3'd1, 8'h00);
        @(negedge clk);
        checkOutput("cin_prev_carry", {15'd0, aluCin}, 16'd1);
        applyStimulus(8'hA1, 3'd1, 8'h00, 3'd0, 8'h01, 4'b1100);

        $display("[TB] OR with immediate, flags untouched");
        loadReg(3'd0, 8'h0F);
        applyStimulus(8'hD4, 3'd5, 8'hF0, 3'd0, 8'hFF, 4'b1100);

        $display("[TB] RN equal to R0");
        loadReg(3'd0, 8'h21);
        applyStimulus(8'h81, 3'd0, 8'h00, 3'd0, 8'h42, 4'b0100);

        $display("[TB] op_valid held for 12 cycles");
        loadReg(3'd0, 8'h77);
        begin
            exp_t e;
            e.addr  = 3'd0;
            e.data  = 8'h00;
            e.flags = 4'b0100;
            repeat (3) sbQ.push_back(e);
        end
        startIdx = acceptLog.size();
        @(negedge clk);
        opIf.op_valid = 1'b1;
        opIf.op_code  = 8'h00;
        opIf.op_rn    = 3'd2;
        opIf.op_imm   = 8'h00;
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("hold_ready_%0d", i), {15'd0, opIf.op_ready}, 16'(i % 5 == 0));
            @(negedge clk);
        end
        opIf.op_valid = 1'b0;
        checkOutput("hold_accepts", 16'(acceptLog.size() - startIdx), 16'd3);
        if (acceptLog.size() - startIdx == 3) begin
            checkOutput("hold_gap1", 16'(acceptLog[startIdx+1] - acceptLog[startIdx]), 16'd5);
            checkOutput("hold_gap2", 16'(acceptLog[startIdx+2] - acceptLog[startIdx]), 16'd10);
        end
        waitIdle("hold_complete_timeout");

        $display("[TB] reset during EXEC");
        loadReg(3'd0, 8'h33);
        loadReg(3'd3, 8'h44);
        checkOutput("pre_abort_flags", {12'd0, flagsQ}, 16'b0100);
        @(negedge clk);
        opIf.op_valid = 1'b1;
        opIf.op_code  = 8'h83;
        opIf.op_rn    = 3'd3;
        @(negedge clk);
        opIf.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        acceptQ.delete();
        #1;
        checkOutput("abort_we", {15'd0, rfWe}, 16'd0);
        checkOutput("abort_flags", {12'd0, flagsQ}, 16'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_ready", {15'd0, opIf.op_ready}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_no_we_%0d", i), {15'd0, rfWe}, 16'd0);
        end
        checkOutput("abort_cin", {15'd0, aluCin}, 16'd0);
        checkOutput("abort_r3_kept", {8'd0, rf[3]}, 16'h0044);
        rst_n = 1'b1;

        $display("[TB] op after reset release");
        loadReg(3'd0, 8'h05);
        loadReg(3'd3, 8'h0A);
        applyStimulus(8'h83, 3'd3, 8'h00, 3'd3, 8'h0F, 4'b0100);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
